// File: rtl/rv32i_types.sv
// Shared types for the burst-memory responder: FSM state and line geometry.
package rv32i_types;
  localparam int BMEM_BEATS      = 4;
  localparam int BMEM_LINE_BYTES = 32;

  typedef enum logic [1:0] {IDLE, WBURST, WAIT, RBURST} bmem_state_e;
endpackage

// File: rtl/bmem_store.sv
// 64-bit beat store, synchronous single port; a write cycle leaves the read register untouched.
module bmem_store #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [63:0]   wdata_i,
  output logic [63:0]   rdata_o
);
  logic [63:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    else      rdata_o       <= mem_q[addr_i];
  end
endmodule

// File: rtl/bmem_responder.sv
// Line-burst memory responder: 4-beat writes, fixed-latency 4-beat reads, one read outstanding.
// Define BMEM_RESPONDER_CHECK_EN to add the bmem_err protocol-violation pulse.
module bmem_responder
  import rv32i_types::*;
#(
  parameter int MEM_LINES = 256,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bmem_addr,
  input  logic        bmem_read,
  input  logic        bmem_write,
  input  logic [63:0] bmem_wdata,
  output logic        bmem_ready,
  output logic [31:0] bmem_raddr,
  output logic [63:0] bmem_rdata,
  output logic        bmem_rvalid
`ifdef BMEM_RESPONDER_CHECK_EN
  ,
  output logic        bmem_err
`endif
);
  localparam int LW = $clog2(MEM_LINES);
  localparam int AW = LW + 2;
  localparam logic [3:0] LAT_M1  = 4'(LATENCY - 1);
  localparam logic [3:0] LAST_BT = 4'(BMEM_BEATS - 1);

  bmem_state_e   state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   raddr_q, raddr_d;
  logic [LW-1:0] wline_q, wline_d;
  logic          we;
  logic [AW-1:0] waddr, mem_addr;
  logic [63:0]   mem_rdata;
  logic          unused_lo;

  assign unused_lo = ^bmem_addr[4:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    raddr_d = raddr_q;
    wline_d = wline_q;
    we      = 1'b0;
    waddr   = {wline_q, cnt_q[1:0]};
    case (state_q)
      IDLE: begin
        if (bmem_read && !bmem_write) begin
          raddr_d = {bmem_addr[31:5], 5'b0};
          cnt_d   = LAT_M1;
          state_d = WAIT;
        end else if (bmem_write && !bmem_read) begin
          we      = 1'b1;
          wline_d = bmem_addr[LW+4:5];
          waddr   = {bmem_addr[LW+4:5], 2'd0};
          cnt_d   = 4'd1;
          state_d = WBURST;
        end
      end
      WBURST: begin
        if (bmem_write) begin
          we = 1'b1;
          if (cnt_q == LAST_BT) begin
            cnt_d   = 4'd0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RBURST;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RBURST: begin
        if (cnt_q == LAST_BT) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reads are issued on the edge that enters/advances RBURST so data lines up with rvalid.
    mem_addr = we ? waddr : {raddr_q[LW+4:5], cnt_d[1:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      raddr_q <= '0;
      wline_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      raddr_q <= raddr_d;
      wline_q <= wline_d;
    end
  end

  bmem_store #(.DEPTH(MEM_LINES * BMEM_BEATS), .AW(AW)) u_store (
    .clk     (clk),
    .we_i    (we),
    .addr_i  (mem_addr),
    .wdata_i (bmem_wdata),
    .rdata_o (mem_rdata)
  );

  assign bmem_ready  = !rst && (state_q == IDLE || state_q == WBURST);
  assign bmem_rvalid = (state_q == RBURST);
  assign bmem_rdata  = bmem_rvalid ? mem_rdata : 64'd0;
  assign bmem_raddr  = raddr_q;

`ifdef BMEM_RESPONDER_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = 1'b0;
    if (state_q == IDLE && bmem_read && bmem_write)                        err_d = 1'b1;
    if (state_q == IDLE && (bmem_read ^ bmem_write) && |bmem_addr[4:0])    err_d = 1'b1;
    if (state_q == WBURST && bmem_read)                                    err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bmem_err = err_q;
`endif
endmodule

// File: tb/tb_bmem_responder.sv
// Scoreboard bench: two responders (LATENCY 4 and 1) share the write bus; read beats checked against a line model.
module tb_bmem_responder;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] addr = '0;
  logic        rd0 = 1'b0, rd1 = 1'b0, wr = 1'b0;
  logic [63:0] wdata = '0;
  logic        rdy0, rdy1, rv0, rv1;
  logic [31:0] ra0, ra1;
  logic [63:0] rdat0, rdat1;
`ifdef BMEM_RESPONDER_CHECK_EN
  logic        err0, err1;
`endif

  int n_chk = 0, n_fail = 0, cyc = 0;
  int acc0 = 0, acc1 = 0, b0 = 0, b1 = 0;
  logic [63:0] mem_m [int];
  logic [63:0] eq0[$], eq1[$];
  logic [31:0] aq0[$], aq1[$];

  bmem_responder #(.MEM_LINES(256), .LATENCY(4)) u0 (
    .clk(clk), .rst(rst), .bmem_addr(addr), .bmem_read(rd0), .bmem_write(wr),
    .bmem_wdata(wdata), .bmem_ready(rdy0), .bmem_raddr(ra0), .bmem_rdata(rdat0),
    .bmem_rvalid(rv0)
`ifdef BMEM_RESPONDER_CHECK_EN
    , .bmem_err(err0)
`endif
  );

  bmem_responder #(.MEM_LINES(256), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .bmem_addr(addr), .bmem_read(rd1), .bmem_write(wr),
    .bmem_wdata(wdata), .bmem_ready(rdy1), .bmem_raddr(ra1), .bmem_rdata(rdat1),
    .bmem_rvalid(rv1)
`ifdef BMEM_RESPONDER_CHECK_EN
    , .bmem_err(err1)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (rv0) begin
      if (eq0.size() == 0) chk("rv0_extra", 1, 0);
      else begin
        if (b0 == 0) chk("lat0", 64'(cyc - acc0), 4);
        chk("rdata0", rdat0, eq0.pop_front());
        chk("raddr0", ra0, aq0.pop_front());
        b0 = (b0 + 1) % 4;
      end
    end else chk("rdata0_idle", rdat0, 0);
  end

  always @(negedge clk) if (!rst) begin
    if (rv1) begin
      if (eq1.size() == 0) chk("rv1_extra", 1, 0);
      else begin
        if (b1 == 0) chk("lat1", 64'(cyc - acc1), 1);
        chk("rdata1", rdat1, eq1.pop_front());
        chk("raddr1", ra1, aq1.pop_front());
        b1 = (b1 + 1) % 4;
      end
    end else chk("rdata1_idle", rdat1, 0);
  end

  function automatic int key(input logic [31:0] a, input int i);
    return int'((a >> 5) & 32'd255) * 4 + i;
  endfunction

  // Starts and ends at posedge+1.
  task automatic wr_line(input logic [31:0] a, input logic [63:0] d [4], input bit stall);
    for (int i = 0; i < 4; i++) begin
      addr = a; wr = 1'b1; wdata = d[i];
      @(negedge clk) chk("wr_rdy", rdy0, 1);
      @(posedge clk) #1;
      mem_m[key(a, i)] = d[i];
      if (stall && i == 1) begin
        wr = 1'b0; wdata = 64'hDEAD_BEEF_DEAD_BEEF;
        repeat (2) begin
          @(negedge clk) chk("stall_rdy", rdy0, 1);
          @(posedge clk) #1;
        end
      end
    end
    wr = 1'b0;
  endtask

  task automatic rd_line(input bit u, input logic [31:0] a);
    int L = u ? 1 : 4;
    addr = a;
    for (int i = 0; i < 4; i++) begin
      if (u) begin eq1.push_back(mem_m[key(a, i)]); aq1.push_back({a[31:5], 5'b0}); end
      else   begin eq0.push_back(mem_m[key(a, i)]); aq0.push_back({a[31:5], 5'b0}); end
    end
    if (u) rd1 = 1'b1; else rd0 = 1'b1;
    @(posedge clk) #1;
    rd0 = 1'b0; rd1 = 1'b0;
    if (u) acc1 = cyc; else acc0 = cyc;
    for (int i = 0; i < L + 4; i++) begin
      @(negedge clk) chk("rdy_busy", u ? rdy1 : rdy0, 0);
`ifdef BMEM_RESPONDER_CHECK_EN
      if (i < 2) chk("err_acc", u ? err1 : err0, (i == 0 && a[4:0] != 0) ? 1 : 0);
`endif
    end
    @(negedge clk) chk("rdy_back", u ? rdy1 : rdy0, 1);
    @(posedge clk) #1;
  endtask

  initial begin
    logic [63:0] d [4];
    logic [31:0] ra;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", rdy0, 0);
    chk("rst_rv", rv0, 0);
    chk("rst_rdata", rdat0, 0);
    chk("rst_raddr", ra0, 0);
    rst = 1'b0;
    @(posedge clk) #1;

    // Write then immediate read of the same line.
    d = '{64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333, 64'h4444444444444444};
    wr_line(32'h40, d, 1'b0);
    rd_line(1'b0, 32'h40);

    // Stalled write burst, then LATENCY=1 read.
    d = '{64'hA0A0A0A0_00000000, 64'hA1A1A1A1_11111111, 64'hA2A2A2A2_22222222, 64'hA3A3A3A3_33333333};
    wr_line(32'h0, d, 1'b1);
    rd_line(1'b1, 32'h0);

    // Address wrap modulo 256 lines.
    rd_line(1'b0, 32'h2040);

    // Simultaneous read+write: ignored, state stays IDLE, store untouched.
    addr = 32'h40; rd0 = 1'b1; rd1 = 1'b1; wr = 1'b1; wdata = 64'hBAD0BAD0BAD0BAD0;
    @(posedge clk) #1;
    rd0 = 1'b0; rd1 = 1'b0; wr = 1'b0;
    @(negedge clk) chk("illegal_rdy", rdy0, 1);
    chk("illegal_rv", rv0, 0);
`ifdef BMEM_RESPONDER_CHECK_EN
    chk("illegal_err", err0, 1);
    @(negedge clk) chk("illegal_err_clr", err0, 0);
`endif
    @(posedge clk) #1;
    rd_line(1'b0, 32'h40);
    rd_line(1'b0, 32'h44);

    for (int k = 0; k < 3; k++) begin
      ra = $urandom() & 32'hFFFF_FFE0;
      for (int i = 0; i < 4; i++) d[i] = {$urandom(), $urandom()};
      wr_line(ra, d, k[0]);
      rd_line(k[1], ra);
    end

    // Reset during beat 2 of a read burst.
    addr = 32'h40;
    for (int i = 0; i < 4; i++) begin eq0.push_back(mem_m[key(32'h40, i)]); aq0.push_back(32'h40); end
    rd0 = 1'b1;
    @(posedge clk) #1;
    rd0 = 1'b0; acc0 = cyc;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_rv", rv0, 0);
    chk("mid_rst_rdata", rdat0, 0);
    chk("mid_rst_raddr", ra0, 0);
    chk("mid_rst_rdy", rdy0, 0);
    chk("mid_rst_beats", 64'(eq0.size()), 2);
    eq0.delete(); aq0.delete(); b0 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk) #1;
    rd_line(1'b0, 32'h40);
    rd_line(1'b1, 32'h0);

    repeat (3) @(posedge clk);
    chk("q0_empty", 64'(eq0.size()), 0);
    chk("q1_empty", 64'(eq1.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/bmem_responder.md
BMEM_RESPONDER -- requirements
Module: bmem_responder

Interface
REQ-001 SHALL have parameter MEM_LINES, default 256, meaning the number of 32-byte lines in the backing store (power of two).
REQ-002 SHALL have parameter LATENCY, default 4, meaning cycles from read accept to first rvalid beat (legal range 1..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port bmem_addr, input, 32, the line address of the request (bits [4:0] ignored).
REQ-006 SHALL have port bmem_read, input, 1, the read request.
REQ-007 SHALL have port bmem_write, input, 1, the write request/beat-valid.
REQ-008 SHALL have port bmem_wdata, input, 64, the write beat data.
REQ-009 SHALL have port bmem_ready, output, 1, the request/beat acceptance.
REQ-010 SHALL have port bmem_raddr, output, 32, the line address of the read burst in flight.
REQ-011 SHALL have port bmem_rdata, output, 64, the read beat data.
REQ-012 SHALL have port bmem_rvalid, output, 1, the read beat valid.

Function
REQ-013 SHALL implement states IDLE, WBURST, WAIT, RBURST.
REQ-014 SHALL assert bmem_ready in IDLE and WBURST only; deassert it in WAIT and RBURST (one outstanding read).
REQ-015 SHALL accept a read in IDLE when bmem_read=1 and bmem_write=0, latch {bmem_addr[31:5],5'b0}, load the latency counter with LATENCY-1, and enter WAIT.
REQ-016 SHALL decrement the counter in WAIT and enter RBURST when it reaches 0, so the first rvalid occurs exactly LATENCY cycles after the accept edge.
REQ-017 SHALL drive 4 consecutive rvalid beats in RBURST, beat i carrying line bytes [8i+7:8i], with bmem_raddr equal to the latched address on all beats, then return to IDLE.
REQ-018 SHALL accept write beat 0 in IDLE when bmem_write=1 and bmem_read=0, store it, and enter WBURST with the beat counter at 1.
REQ-019 SHALL store one beat per cycle in WBURST while bmem_write=1, and return to IDLE after beat 3.
REQ-020 SHALL hold the state and counter in WBURST while bmem_write=0 (a stalled beat).
REQ-021 SHALL treat bmem_read=1 together with bmem_write=1 in IDLE as illegal: no accept, no state change.
REQ-022 SHALL index storage by addr[$clog2(MEM_LINES)+4:5]; upper address bits wrap modulo the store size.
REQ-023 SHALL make a read accepted the cycle after a write burst's final beat return the new data (write-then-read coherence).
REQ-024 SHALL hold bmem_rdata at 0 when bmem_rvalid=0.

Reset
REQ-025 SHALL on rst: state IDLE, counters 0, bmem_ready=0 while rst is high, bmem_rvalid=0, bmem_rdata=0, bmem_raddr=0.
REQ-026 SHALL abort any burst in progress when reset asserts mid-burst; the store contents are not cleared.

Configuration
REQ-027 SHALL, with macro BMEM_RESPONDER_CHECK_EN defined, add output bmem_err (1 bit), pulsed for one cycle on any illegal simultaneous read+write, any nonzero bmem_addr[4:0] at accept, or bmem_read=1 during WBURST.
REQ-028 SHALL, without BMEM_RESPONDER_CHECK_EN, have no bmem_err port and silently ignore those conditions.

Structure
REQ-029 SHALL place the state enum, BMEM_BEATS=4, and BMEM_LINE_BYTES=32 in rv32i_types.
REQ-030 SHALL use one sub-module, bmem_store: a 64-bit x (MEM_LINES*4) synchronous single-port array with beat-granular write enable.

Verification
REQ-031 SHALL cover: write of beats 0x11..,0x22..,0x33..,0x44.. to 0x00000040, then read at 0x40 -> rvalid at +4 cycles, beats returned in order, raddr=0x40.
REQ-032 SHALL cover: LATENCY=1, read at 0x0 -> rvalid on the first cycle after accept; 4 beats; ready low for 5 cycles.
REQ-033 SHALL cover: a write burst with bmem_write dropped for 2 cycles after beat 1 -> remaining beats stored correctly, no extra beats consumed.
REQ-034 SHALL cover: read with MEM_LINES=256 at 0x00002040 -> same data as 0x40 (wrap).
REQ-035 SHALL cover: rst asserted during RBURST beat 2 -> rvalid=0 immediately; a subsequent read returns intact data.
REQ-036 SHALL cover, with BMEM_RESPONDER_CHECK_EN defined: read+write together, or address 0x44 -> bmem_err pulses for one cycle; in the read+write case the state stays IDLE.
